// File: rtl/yolo_params_pkg.sv
// Shared sizing, bus types and FSM encoding for the convolution product generator.
// IFMAP_SIZE assumes stride 1 with no padding.
package yolo_params_pkg;

  localparam int IP_DATA_WIDTH = 8;
  localparam int FILTER_SIZE   = 3;
  localparam int OFMAP_SIZE    = 4;
  localparam int IFMAP_SIZE    = OFMAP_SIZE + FILTER_SIZE - 1;

  localparam int FILT_AREA  = FILTER_SIZE * FILTER_SIZE;
  localparam int IFMAP_AREA = IFMAP_SIZE * IFMAP_SIZE;
  localparam int OFMAP_AREA = OFMAP_SIZE * OFMAP_SIZE;
  localparam int PROD_WIDTH = 2 * IP_DATA_WIDTH;

  localparam int IDX_W    = $clog2(OFMAP_AREA);
  localparam int RC_W     = $clog2(OFMAP_SIZE);
  localparam int WT_CNT_W = $clog2(FILT_AREA);
  localparam int PX_CNT_W = $clog2(IFMAP_AREA);

  typedef logic [FILT_AREA-1:0][IP_DATA_WIDTH-1:0] win_t;
  typedef logic [FILT_AREA-1:0][PROD_WIDTH-1:0]    prod_vec_t;

  typedef enum logic [1:0] {
    LOAD_WT = 2'd0,
    LOAD_PX = 2'd1,
    EMIT    = 2'd2
  } conv_state_t;

endpackage

// File: rtl/conv_window_mul.sv
// Unsigned full-precision multiply of one filter window by the weight set.
// Purely combinational, zero latency, no flow control.
module conv_window_mul
  import yolo_params_pkg::*;
(
  input  win_t      win,
  input  win_t      wts,
  output prod_vec_t prods
);

  always_comb begin
    prods = '0;
    for (int k = 0; k < FILT_AREA; k++)
      prods[k] = PROD_WIDTH'(win[k]) * PROD_WIDTH'(wts[k]);
  end

endmodule

// File: rtl/conv_prod_gen.sv
// Loads a weight set and an ifmap, then streams one window product vector per output position.
// First vector one cycle after the last pixel handshake; outputs held while prod_ready is low.
module conv_prod_gen
  import yolo_params_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wt_valid,
  output logic                     wt_ready,
  input  logic [IP_DATA_WIDTH-1:0] wt_data,
  input  logic                     px_valid,
  output logic                     px_ready,
  input  logic [IP_DATA_WIDTH-1:0] px_data,
  output logic                     prod_valid,
  input  logic                     prod_ready,
  output prod_vec_t                prod_vec,
  output logic [IDX_W-1:0]         prod_idx,
  output logic                     prod_last,
  output logic                     busy
);

  localparam logic [WT_CNT_W-1:0] WT_LAST  = WT_CNT_W'(FILT_AREA - 1);
  localparam logic [PX_CNT_W-1:0] PX_LAST  = PX_CNT_W'(IFMAP_AREA - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(OFMAP_AREA - 1);
  localparam logic [RC_W-1:0]     RC_LAST  = RC_W'(OFMAP_SIZE - 1);

  conv_state_t state, state_nxt;

  logic [WT_CNT_W-1:0]      wt_cnt;
  logic [PX_CNT_W-1:0]      px_cnt;
  logic [RC_W-1:0]          nxt_r, nxt_c;
  logic [IDX_W-1:0]         nxt_idx;
  logic                     wt_acc, px_acc;
  logic                     load_out, clr_out;

  win_t                     wt_q;
  logic [IP_DATA_WIDTH-1:0] px_mem [IFMAP_AREA];
  logic [PX_CNT_W-1:0]      win_addr [FILT_AREA];
  win_t                     win;
  prod_vec_t                prods;

  assign nxt_idx = IDX_W'(int'(nxt_r) * OFMAP_SIZE + int'(nxt_c));

  always_comb begin
    state_nxt = state;
    wt_ready  = 1'b0;
    px_ready  = 1'b0;
    busy      = 1'b0;
    load_out  = 1'b0;
    clr_out   = 1'b0;
    case (state)
      LOAD_WT: begin
        wt_ready = 1'b1;
        if (wt_valid && wt_cnt == WT_LAST)
          state_nxt = LOAD_PX;
      end
      LOAD_PX: begin
        px_ready = 1'b1;
        busy     = 1'b1;
        // Window (0,0) never contains the final pixel, so it can be launched on that same edge.
        if (px_valid && px_cnt == PX_LAST) begin
          state_nxt = EMIT;
          load_out  = 1'b1;
        end
      end
      EMIT: begin
        busy = 1'b1;
        if (prod_valid && prod_ready) begin
          if (prod_last) begin
            state_nxt = LOAD_WT;
            clr_out   = 1'b1;
          end else begin
            load_out = 1'b1;
          end
        end
      end
      default: state_nxt = LOAD_WT;
    endcase
    wt_acc = wt_valid && wt_ready;
    px_acc = px_valid && px_ready;
  end

  // Window gather for the position that will be loaded next.
  always_comb begin
    win = '0;
    for (int k = 0; k < FILT_AREA; k++) begin
      win_addr[k] = PX_CNT_W'((int'(nxt_r) + k / FILTER_SIZE) * IFMAP_SIZE
                              + int'(nxt_c) + k % FILTER_SIZE);
      win[k]      = px_mem[win_addr[k]];
    end
  end

  conv_window_mul u_mul (
    .win   (win),
    .wts   (wt_q),
    .prods (prods)
  );

  always_ff @(posedge clk) begin
    if (wt_acc)
      wt_q[wt_cnt] <= wt_data;
    if (px_acc)
      px_mem[px_cnt] <= px_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD_WT;
      wt_cnt     <= '0;
      px_cnt     <= '0;
      nxt_r      <= '0;
      nxt_c      <= '0;
      prod_valid <= 1'b0;
      prod_vec   <= '0;
      prod_idx   <= '0;
      prod_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wt_acc)
        wt_cnt <= (wt_cnt == WT_LAST) ? '0 : wt_cnt + WT_CNT_W'(1);
      if (px_acc)
        px_cnt <= (px_cnt == PX_LAST) ? '0 : px_cnt + PX_CNT_W'(1);
      if (load_out) begin
        prod_valid <= 1'b1;
        prod_vec   <= prods;
        prod_idx   <= nxt_idx;
        prod_last  <= (nxt_idx == IDX_LAST);
        if (nxt_c == RC_LAST) begin
          nxt_c <= '0;
          nxt_r <= (nxt_r == RC_LAST) ? '0 : nxt_r + RC_W'(1);
        end else begin
          nxt_c <= nxt_c + RC_W'(1);
        end
      end else if (clr_out) begin
        prod_valid <= 1'b0;
        prod_last  <= 1'b0;
        nxt_r      <= '0;
        nxt_c      <= '0;
      end
    end
  end

endmodule

// File: doc/conv_prod_gen.md
CONV_PROD_GEN -- requirements
Module: conv_prod_gen

Interface
REQ-001 SHALL import yolo_params_pkg for parameters IP_DATA_WIDTH (pixel/weight width), FILTER_SIZE (filter edge) and OFMAP_SIZE (output edge).
REQ-002 SHALL use IFMAP_SIZE = OFMAP_SIZE+FILTER_SIZE-1 from the package (stride 1, no padding).
REQ-003 clk  input  1  sole clock; all state changes on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wt_valid / wt_ready  input / output  1 / 1  weight handshake.
REQ-006 wt_data  input  IP_DATA_WIDTH  unsigned weight, row-major.
REQ-007 px_valid / px_ready  input / output  1 / 1  pixel handshake.
REQ-008 px_data  input  IP_DATA_WIDTH  unsigned ifmap pixel, raster order.
REQ-009 prod_valid / prod_ready  output / input  1 / 1  product-vector handshake toward the row-sum MAC.
REQ-010 prod_vec  output  [FILTER_SIZE*FILTER_SIZE] x 2*IP_DATA_WIDTH  products of one window, element k = window(k/FILTER_SIZE, k%FILTER_SIZE) * weight[k].
REQ-011 prod_idx  output  $clog2(OFMAP_SIZE*OFMAP_SIZE)  output position, row*OFMAP_SIZE+col.
REQ-012 prod_last  output  1  high with the vector for index OFMAP_SIZE*OFMAP_SIZE-1.
REQ-013 busy  output  1  high in LOAD_PX and EMIT.

Function
REQ-014 SHALL implement FSM LOAD_WT -> LOAD_PX -> EMIT -> LOAD_WT.
REQ-015 LOAD_WT: wt_ready=1, px_ready=0; each wt_valid&&wt_ready stores one weight; after FILTER_SIZE^2 accepts go to LOAD_PX.
REQ-016 LOAD_PX: px_ready=1, wt_ready=0; store IFMAP_SIZE^2 pixels; after last accept go to EMIT.
REQ-017 EMIT: wt_ready=px_ready=0; valid inputs in other states SHALL be ignored and not stored.
REQ-018 First prod_valid SHALL assert exactly one cycle after the final pixel handshake.
REQ-019 prod_vec, prod_idx, prod_last SHALL be registered and held stable while prod_valid&&!prod_ready.
REQ-020 On prod_valid&&prod_ready the next index SHALL be presented the following cycle (one vector per cycle at full throughput).
REQ-021 Handshake on prod_last SHALL deassert prod_valid and enter LOAD_WT next cycle; weight and pixel stores need not be cleared.
REQ-022 Multiplication unsigned, full 2*IP_DATA_WIDTH precision, no truncation or saturation.
REQ-023 Window for index (r,c) SHALL cover pixels rows r..r+FILTER_SIZE-1, cols c..c+FILTER_SIZE-1.

Reset
REQ-024 rst low SHALL immediately force LOAD_WT, all counters 0, prod_valid/prod_last/busy 0, prod_vec/prod_idx 0, regardless of state (including mid-EMIT).
REQ-025 wt_ready SHALL be 1 from the first cycle after rst deasserts.

Structure
REQ-026 IFMAP_SIZE and the FSM state enum SHALL live in yolo_params_pkg.
REQ-027 One sub-module conv_window_mul (combinational FILTER_SIZE^2 multiplier array) SHALL be instantiated; its outputs feed the registered output stage.

Verification (IP_DATA_WIDTH=8, FILTER_SIZE=3, OFMAP_SIZE=4, IFMAP_SIZE=6)
REQ-028 Weights all 1, pixels 0..35 -> idx0 vec {0,1,2,6,7,8,12,13,14}; idx15 vec {21,22,23,27,28,29,33,34,35} with prod_last=1; 16 vectors total.
REQ-029 Weights 255, pixels 255, prod_ready=1 -> every element 65025, 16 consecutive valid cycles.
REQ-030 prod_ready low 5 cycles while idx=5 presented -> idx/vec unchanged for 5 cycles, idx6 one cycle after ready returns.
REQ-031 px_valid high during LOAD_WT, or wt_valid high during LOAD_PX/EMIT -> corresponding ready 0, no store, outputs identical to REQ-028.
REQ-032 rst low at idx7 in EMIT -> outputs zero same cycle; next full frame reproduces REQ-028 exactly.
REQ-033 Two frames back-to-back -> wt_ready high the cycle after frame-1 prod_last handshake; frame-2 results correct with new weights.
